i2s_frame_controller: RTL and testbench

Sequences the audio codec serial port for the drum game. It generates BCLK and LRCLK from the system clock and serializes one stereo sample per frame in I2S format. It pulls samples from the upstream voice mixer through a ready/valid handshake. When no sample is waiting at a frame boundary, it transmits silence and counts the underrun.

---
 rtl/i2s_frame_if.sv | 12 +
 rtl/i2s_frame_controller.sv | 110 +++++++++++
 tb/tb_i2s_frame_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_if.sv
// i2s_frame_if: ready/valid stereo sample handshake between the voice mixer and the I2S controller
interface i2s_frame_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
    modport slave (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_frame_controller.sv
// i2s_frame_controller: generates BCLK/LRCLK and serializes one stereo sample per frame in I2S format
module i2s_frame_controller #(
    parameter int BCLK_HALF = 4,
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    i2s_frame_if.slave  up,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic [7:0]  underrun_cnt
);
    localparam int DW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
    localparam int BW = $clog2(SLOT_W);

    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                bclk_q, bclk_d;
    logic                lr_q, lr_d;
    logic                sd_q, sd_d;
    logic                fs_q, fs_d;
    logic                full_q, full_d;
    logic                rdy_q, rdy_d;
    logic [SAMPLE_W-1:0] hl_q, hl_d, hr_q, hr_d;
    logic [SAMPLE_W-1:0] sl_q, sl_d, sr_q, sr_d;
    logic [7:0]          ur_q, ur_d;
    logic                term, fall, wrap, load, accept, shift;

    // Divider, slot counter, shifters and holding register; en low forces the idle values
    always_comb begin
        term = div_q == DW'(BCLK_HALF - 1);
        fall = term && bclk_q;
        wrap = fall && bit_q == BW'(SLOT_W - 1);
        load = wrap && lr_q;
        accept = up.sample_valid && rdy_q;
        div_d = term ? '0 : div_q + 1'b1;
        bclk_d = bclk_q ^ term;
        bit_d = wrap ? '0 : (fall ? bit_q + 1'b1 : bit_q);
        lr_d = lr_q ^ wrap;
        shift = fall && bit_d != '0 && bit_d <= BW'(SAMPLE_W);
        sd_d = shift ? (lr_d ? sr_q[SAMPLE_W-1] : sl_q[SAMPLE_W-1]) : (fall ? 1'b0 : sd_q);
        sl_d = load ? (full_q ? hl_q : '0) : (shift && !lr_d ? sl_q << 1 : sl_q);
        sr_d = load ? (full_q ? hr_q : '0) : (shift && lr_d ? sr_q << 1 : sr_q);
        full_d = accept || (full_q && !load);
        hl_d = accept ? up.sample_l : hl_q;
        hr_d = accept ? up.sample_r : hr_q;
        rdy_d = !full_d;
        fs_d = load;
        ur_d = ur_q + 8'(load && !full_q && ur_q != 8'hFF);
        if (!en) begin
            div_d = '0;
            bclk_d = 1'b0;
            bit_d = BW'(SLOT_W - 1);
            lr_d = 1'b1;
            sd_d = 1'b0;
            sl_d = '0;
            sr_d = '0;
            hl_d = '0;
            hr_d = '0;
            full_d = 1'b0;
            rdy_d = 1'b0;
            fs_d = 1'b0;
            ur_d = ur_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            bclk_q <= 1'b0;
            bit_q <= BW'(SLOT_W - 1);
            lr_q <= 1'b1;
            sd_q <= 1'b0;
            fs_q <= 1'b0;
            full_q <= 1'b0;
            rdy_q <= 1'b0;
            hl_q <= '0;
            hr_q <= '0;
            sl_q <= '0;
            sr_q <= '0;
            ur_q <= '0;
        end else begin
            div_q <= div_d;
            bclk_q <= bclk_d;
            bit_q <= bit_d;
            lr_q <= lr_d;
            sd_q <= sd_d;
            fs_q <= fs_d;
            full_q <= full_d;
            rdy_q <= rdy_d;
            hl_q <= hl_d;
            hr_q <= hr_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    assign bclk = bclk_q;
    assign lrclk = lr_q;
    assign sdata = sd_q;
    assign frame_start = fs_q;
    assign underrun_cnt = ur_q;
    assign up.sample_ready = rdy_q;
endmodule

// File: tb/tb_i2s_frame_controller.sv
// tb_i2s_frame_controller: randomized and directed checks of two controller configurations against a timeline model
module tb_i2s_frame_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, en_v, bclk_o, lr_o, sd_o, fs_o;
    logic [7:0] ur0, ur1;
    int checks = 0;
    int errors = 0;

    i2s_frame_if #(.SAMPLE_W(16)) up0();
    i2s_frame_if #(.SAMPLE_W(16)) up1();

    i2s_frame_controller #(.BCLK_HALF(4), .SAMPLE_W(16), .SLOT_W(32)) dut0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up(up0), .bclk(bclk_o[0]), .lrclk(lr_o[0]),
        .sdata(sd_o[0]), .frame_start(fs_o[0]), .underrun_cnt(ur0)
    );
    i2s_frame_controller #(.BCLK_HALF(1), .SAMPLE_W(16), .SLOT_W(17)) dut1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up1), .bclk(bclk_o[1]), .lrclk(lr_o[1]),
        .sdata(sd_o[1]), .frame_start(fs_o[1]), .underrun_cnt(ur1)
    );

    // Model: t = clk edges since leaving idle; everything else follows from the I2S timeline
    int t[2];
    int ur[2];
    bit full[2];
    bit rdy[2];
    logic [15:0] hl[2], hr[2];
    logic [15:0] fl[2][64], fr[2][64];

    function automatic int hh(int i); return i != 0 ? 1 : 4; endfunction
    function automatic int ss(int i); return i != 0 ? 17 : 32; endfunction

    function automatic bit is_load(int i, int tt);
        int p = 2 * hh(i);
        return tt > 0 && tt % p == 0 && (tt / p - 1) % (2 * ss(i)) == 0;
    endfunction

    function automatic logic exp_sd(int i);
        int f, p, n, k, s;
        logic [15:0] w;
        s = ss(i);
        f = t[i] / (2 * hh(i));
        if (f == 0) return 1'b0;
        p = (f - 1) % (2 * s);
        n = ((f - 1) / (2 * s)) % 64;
        k = p % s;
        if (k < 1 || k > 16) return 1'b0;
        w = p >= s ? fr[i][n] : fl[i][n];
        return w[4'(16 - k)];
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic mdl(int i);
        logic v;
        logic [15:0] l, r;
        bit acc;
        int n;
        v = i != 0 ? up1.sample_valid : up0.sample_valid;
        l = i != 0 ? up1.sample_l : up0.sample_l;
        r = i != 0 ? up1.sample_r : up0.sample_r;
        if (rst_v[i] || !en_v[i]) begin
            t[i] = 0;
            full[i] = 1'b0;
            rdy[i] = 1'b0;
            if (rst_v[i]) ur[i] = 0;
        end else begin
            acc = v && rdy[i];
            t[i]++;
            if (is_load(i, t[i])) begin
                n = ((t[i] / (2 * hh(i)) - 1) / (2 * ss(i))) % 64;
                fl[i][n] = full[i] ? hl[i] : 16'h0;
                fr[i][n] = full[i] ? hr[i] : 16'h0;
                if (!full[i] && ur[i] < 255) ur[i]++;
                full[i] = 1'b0;
            end
            if (acc) begin
                hl[i] = l;
                hr[i] = r;
                full[i] = 1'b1;
            end
            rdy[i] = !full[i];
        end
    endtask

    task automatic verify(int i);
        int h, s, f;
        h = hh(i);
        s = ss(i);
        f = t[i] / (2 * h);
        chk($sformatf("bclk%0d", i), 64'(bclk_o[i]), 64'((t[i] / h) % 2));
        chk($sformatf("lrclk%0d", i), 64'(lr_o[i]), 64'(f == 0 ? 1 : ((f - 1) / s) % 2));
        chk($sformatf("sdata%0d", i), 64'(sd_o[i]), 64'(exp_sd(i)));
        chk($sformatf("frame_start%0d", i), 64'(fs_o[i]), 64'(is_load(i, t[i])));
        chk($sformatf("ready%0d", i), 64'(i != 0 ? up1.sample_ready : up0.sample_ready), 64'(rdy[i]));
        chk($sformatf("underrun%0d", i), 64'(i != 0 ? ur1 : ur0), 64'(ur[i]));
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            mdl(0);
            mdl(1);
            @(posedge clk);
            #1;
            verify(0);
            verify(1);
        end
    endtask

    task automatic wait_fs(int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            cyc(1);
            if (fs_o[i]) ok = 1'b1;
        end
    endtask

    // Collect sdata on nb bclk rises starting from the next frame_start
    task automatic grab(int i, int nb, output logic [63:0] v);
        bit ok;
        int got = 0;
        logic pb;
        v = '0;
        wait_fs(i, ok);
        pb = bclk_o[i];
        for (int c = 0; c < 4000 && got < nb; c++) begin
            cyc(1);
            if (bclk_o[i] && !pb) begin
                v = {v[62:0], sd_o[i]};
                got++;
            end
            pb = bclk_o[i];
        end
        chk($sformatf("grab%0d_done", i), 64'(ok && got == nb), 64'd1);
    endtask

    task automatic lr_period(int i, output int p);
        int f1 = -1;
        logic pl = lr_o[i];
        p = -1;
        for (int c = 0; c < 3000 && p < 0; c++) begin
            cyc(1);
            if (pl && !lr_o[i]) begin
                if (f1 < 0) f1 = c;
                else p = c - f1;
            end
            pl = lr_o[i];
        end
    endtask

    initial begin
        logic [63:0] cap;
        logic [15:0] l3;
        int per, nfs, ones, first_rise, first_fs, u_start;
        bit found, mode;
        rst_v = 2'b11;
        en_v = 2'b11;
        up0.sample_valid = 1'b0;
        up0.sample_l = '0;
        up0.sample_r = '0;
        up1.sample_valid = 1'b0;
        up1.sample_l = '0;
        up1.sample_r = '0;
        cyc(3);
        chk("reset_lrclk", 64'(lr_o[0]), 64'd1);
        chk("reset_ready", 64'(up0.sample_ready), 64'd0);
        // Held-valid known sample: one full frame of bits on bclk rises
        up0.sample_l = 16'hA55A;
        up0.sample_r = 16'h0F0F;
        up0.sample_valid = 1'b1;
        rst_v[0] = 1'b0;
        grab(0, 64, cap);
        chk("a55a_frame", cap, {1'b0, 16'hA55A, 15'h0, 1'b0, 16'h0F0F, 15'h0});
        lr_period(0, per);
        chk("lr_period0", 64'(per), 64'd512);
        // Three frames with no valid
        up0.sample_valid = 1'b0;
        rst_v[0] = 1'b1;
        cyc(1);
        rst_v[0] = 1'b0;
        nfs = 0;
        ones = 0;
        for (int c = 0; c < 1040; c++) begin
            cyc(1);
            nfs += int'(fs_o[0]);
            ones += int'(sd_o[0]);
        end
        chk("silent_fs", 64'(nfs), 64'd3);
        chk("silent_ones", 64'(ones), 64'd0);
        chk("silent_underrun", 64'(ur0), 64'd3);
        // Valid arriving exactly in the load cycle does not rescue that frame
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            if (is_load(0, t[0] + 1)) found = 1'b1;
            else cyc(1);
        end
        chk("late_found", 64'(found), 64'd1);
        l3 = 16'($urandom);
        up0.sample_l = l3;
        up0.sample_r = 16'($urandom);
        up0.sample_valid = 1'b1;
        cyc(1);
        up0.sample_valid = 1'b0;
        chk("late_fs", 64'(fs_o[0]), 64'd1);
        chk("late_underrun", 64'(ur0), 64'd4);
        grab(0, 17, cap);
        chk("late_sample", 64'(cap[16:0]), 64'({1'b0, l3}));
        chk("late_no_underrun", 64'(ur0), 64'd4);
        // Randomized stream with occasional starved frames
        mode = 1'b1;
        for (int c = 0; c < 6 * 512; c++) begin
            if (fs_o[0]) mode = $urandom_range(0, 2) != 0;
            up0.sample_valid = mode && $urandom_range(0, 3) == 0;
            up0.sample_l = 16'($urandom);
            up0.sample_r = 16'($urandom);
            cyc(1);
        end
        // Reset at bit position 8 of the left slot
        up0.sample_valid = 1'b1;
        wait_fs(0, found);
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (t[0] % 8 == 0 && t[0] >= 8 && (t[0] / 8 - 1) % 64 == 8) found = 1'b1;
            else cyc(1);
        end
        chk("mid_found", 64'(found), 64'd1);
        rst_v[0] = 1'b1;
        cyc(1);
        chk("mid_bclk", 64'(bclk_o[0]), 64'd0);
        chk("mid_lrclk", 64'(lr_o[0]), 64'd1);
        chk("mid_sdata", 64'(sd_o[0]), 64'd0);
        chk("mid_ready", 64'(up0.sample_ready), 64'd0);
        rst_v[0] = 1'b0;
        first_rise = -1;
        first_fs = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            if (bclk_o[0] && first_rise < 0) first_rise = c;
            if (fs_o[0] && first_fs < 0) first_fs = c;
        end
        chk("restart_rise", 64'(first_rise), 64'd4);
        chk("restart_fs", 64'(first_fs), 64'd8);
        en_v[0] = 1'b0;
        cyc(3);
        en_v[0] = 1'b1;
        cyc(600);
        rst_v[0] = 1'b1;
        // Small configuration: back-to-back streaming then forced saturation
        up1.sample_valid = 1'b1;
        rst_v[1] = 1'b0;
        cyc(70);
        u_start = int'(ur1);
        for (int c = 0; c < 6 * 68; c++) begin
            up1.sample_l = 16'($urandom);
            up1.sample_r = 16'($urandom);
            cyc(1);
        end
        chk("b2b_underrun", 64'(int'(ur1) - u_start), 64'd0);
        lr_period(1, per);
        chk("lr_period1", 64'(per), 64'd68);
        up1.sample_valid = 1'b0;
        cyc(300 * 68 + 100);
        chk("sat_underrun", 64'(ur1), 64'd255);
        en_v[1] = 1'b0;
        cyc(2);
        en_v[1] = 1'b1;
        cyc(1);
        chk("en_keeps_underrun", 64'(ur1), 64'd255);
        rst_v[1] = 1'b1;
        cyc(1);
        chk("rst_clears_underrun", 64'(ur1), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
